// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointer logic.
// Functions work on a fixed maximum width; callers zero-extend and truncate to their own width.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value; zero-extended upper bits stay zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = gray;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder of parameterised width.
module gray_enc
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = W'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_counter.sv
// Gray-coded FIFO pointer: binary count plus registered Gray output, one bit change per step.
// The unused block input (full on the read side, empty on the write side) is tied low by the user.
module gray_counter
  import gray_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_inc,
  input  logic                i_full,
  input  logic                i_empty,
  output logic [NUM_BITS-1:0] o_gray
);

  logic                w_en;
  logic [NUM_BITS-1:0] w_binNext;
  logic [NUM_BITS-1:0] w_grayNext;
  logic [NUM_BITS-1:0] r_bin;
  logic [NUM_BITS-1:0] r_gray;

  // Block conditions always win over an increment request.
  assign w_en      = i_inc & ~i_full & ~i_empty;
  assign w_binNext = r_bin + NUM_BITS'(1);

  gray_enc #(
    .W (NUM_BITS)
  ) u_enc (
    .i_bin  (w_binNext),
    .o_gray (w_grayNext)
  );

  // Gray is registered from the next binary value so no input-to-output combinational path exists.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (w_en) begin
      r_bin  <= w_binNext;
      r_gray <= w_grayNext;
    end
  end

  assign o_gray = r_gray;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at NUM_BITS=4 and NUM_BITS=3.
module tb_gray_counter;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       full;
  logic       empty;
  logic [3:0] gray;

  logic       rst3;
  logic       inc3;
  logic [2:0] gray3;

  int testCount;
  int failCount;

  logic [3:0] seq4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [2:0] seq3 [8]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  logic [3:0] prev4;
  logic [2:0] prev3;

  gray_counter #(
    .NUM_BITS (4)
  ) dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (inc),
    .i_full  (full),
    .i_empty (empty),
    .o_gray  (gray)
  );

  gray_counter #(
    .NUM_BITS (3)
  ) dut3 (
    .i_clk   (clk),
    .i_rst   (rst3),
    .i_inc   (inc3),
    .i_full  (1'b0),
    .i_empty (1'b0),
    .o_gray  (gray3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input logic f, input logic e);
    inc   = i;
    full  = f;
    empty = e;
  endtask

  // Outputs are sampled 1 ns after the rising edge, inputs change at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst  = 1'b1;
    rst3 = 1'b1;
    inc3 = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    #1;
    checkOutput("reset_async_start", 32'(gray), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("reset_hold_%0d", i), 32'(gray), 32'h0);
    end

    rst   = 1'b0;
    prev4 = gray;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput($sformatf("free_count_%0d", i), 32'(gray), 32'(seq4[i % 16]));
      checkOutput($sformatf("one_bit_step_%0d", i), 32'($countones(gray ^ prev4)), 32'd1);
      prev4 = gray;
    end

    // Reset asserted mid-cycle must clear the output before the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_between_edges", 32'(gray), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("after_reset_first", 32'(gray), 32'(4'b0001));

    for (int i = 0; i < 4; i++) tick();
    checkOutput("five_increments", 32'(gray), 32'(4'b0111));

    @(negedge clk);
    rst = 1'b1;
    #50;
    checkOutput("mid_count_reset", 32'(gray), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("mid_reset_release", 32'(gray), 32'(4'b0001));
    tick();
    tick();
    checkOutput("at_0010", 32'(gray), 32'(4'b0010));

    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("full_hold_%0d", i), 32'(gray), 32'(4'b0010));
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("empty_hold_%0d", i), 32'(gray), 32'(4'b0010));
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("unblocked_step", 32'(gray), 32'(4'b0110));
    tick();
    tick();
    checkOutput("at_0101", 32'(gray), 32'(4'b0101));

    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("inc_low_hold_%0d", i), 32'(gray), 32'(4'b0101));
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("both_block_hold_%0d", i), 32'(gray), 32'(4'b0101));
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("resume_step", 32'(gray), 32'(4'b0100));

    // Narrower instance: full 3-bit cycle plus one step past the wrap.
    checkOutput("n3_reset", 32'(gray3), 32'h0);
    rst3  = 1'b0;
    inc3  = 1'b1;
    prev3 = gray3;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checkOutput($sformatf("n3_count_%0d", i), 32'(gray3), 32'(seq3[i % 8]));
      checkOutput($sformatf("n3_one_bit_step_%0d", i), 32'($countones(gray3 ^ prev3)), 32'd1);
      prev3 = gray3;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
